// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU issue controller: ALU control
// codes, MIPS opcode/funct/REGIMM fields and the decoded-op record.
package alu_ctrl_pkg;

  // ALU control codes
  localparam logic [3:0] CTRL_ADDU = 4'b0000;
  localparam logic [3:0] CTRL_ADD  = 4'b0001;
  localparam logic [3:0] CTRL_SUBU = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0011;
  localparam logic [3:0] CTRL_AND  = 4'b0100;
  localparam logic [3:0] CTRL_OR   = 4'b0101;
  localparam logic [3:0] CTRL_NOR  = 4'b0110;
  localparam logic [3:0] CTRL_XOR  = 4'b0111;
  localparam logic [3:0] CTRL_SLTU = 4'b1000;
  localparam logic [3:0] CTRL_SLT  = 4'b1001;
  localparam logic [3:0] CTRL_BLTZ = 4'b1010;
  localparam logic [3:0] CTRL_BLEZ = 4'b1011;
  localparam logic [3:0] CTRL_BGTZ = 4'b1100;
  localparam logic [3:0] CTRL_BGEZ = 4'b1101;
  localparam logic [3:0] CTRL_LUI  = 4'b1110;
  localparam logic [3:0] CTRL_INV  = 4'b1111;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_SLTIU  = 6'b001011;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_LUI    = 6'b001111;

  // R-type funct field
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // REGIMM rt selectors
  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  // How a branch resolves from the ALU flags
  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10,
    BR_CMP  = 2'b11
  } br_kind_e;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic        b_sel;
    logic [31:0] imm;
    logic        wb;
    logic [4:0]  wb_reg;
    logic        is_branch;
    br_kind_e    br_kind;
    logic        ri;
  } dec_op_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

  // Undecodable encoding: reserved-instruction, no writeback, no branch
  function automatic dec_op_t mk_invalid();
    dec_op_t d;
    d           = '0;
    d.ctrl      = CTRL_INV;
    d.br_kind   = BR_NONE;
    d.ri        = 1'b1;
    return d;
  endfunction

  // Register-register op writing rd
  function automatic dec_op_t mk_rtype(input logic [3:0] ctrl, input logic [4:0] rd);
    dec_op_t d;
    d           = '0;
    d.ctrl      = ctrl;
    d.br_kind   = BR_NONE;
    d.wb        = 1'b1;
    d.wb_reg    = rd;
    return d;
  endfunction

  // Immediate op writing rt, B operand taken from the immediate
  function automatic dec_op_t mk_itype(input logic [3:0] ctrl, input logic [31:0] imm,
                                       input logic [4:0] rt);
    dec_op_t d;
    d           = '0;
    d.ctrl      = ctrl;
    d.b_sel     = 1'b1;
    d.imm       = imm;
    d.br_kind   = BR_NONE;
    d.wb        = 1'b1;
    d.wb_reg    = rt;
    return d;
  endfunction

  // Conditional branch: no writeback, B operand is rt
  function automatic dec_op_t mk_branch(input logic [3:0] ctrl, input br_kind_e kind);
    dec_op_t d;
    d           = '0;
    d.ctrl      = ctrl;
    d.is_branch = 1'b1;
    d.br_kind   = kind;
    return d;
  endfunction

  // Signed add/sub are the only ops that raise an overflow exception
  function automatic logic is_trap_arith(input logic [3:0] ctrl);
    return (ctrl == CTRL_ADD) || (ctrl == CTRL_SUB);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational MIPS instruction decode into the ALU control record.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output dec_op_t     op
);

  logic [5:0]  opcode_s;
  logic [4:0]  rt_s;
  logic [4:0]  rd_s;
  logic [5:0]  funct_s;
  logic [15:0] imm16_s;

  assign opcode_s = instr[31:26];
  assign rt_s     = instr[20:16];
  assign rd_s     = instr[15:11];
  assign funct_s  = instr[5:0];
  assign imm16_s  = instr[15:0];

  // Map opcode/funct/rt onto ctrl code, operand select and writeback info
  always_comb begin
    op = mk_invalid();
    case (opcode_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_ADD:  op = mk_rtype(CTRL_ADD,  rd_s);
          FN_ADDU: op = mk_rtype(CTRL_ADDU, rd_s);
          FN_SUB:  op = mk_rtype(CTRL_SUB,  rd_s);
          FN_SUBU: op = mk_rtype(CTRL_SUBU, rd_s);
          FN_AND:  op = mk_rtype(CTRL_AND,  rd_s);
          FN_OR:   op = mk_rtype(CTRL_OR,   rd_s);
          FN_XOR:  op = mk_rtype(CTRL_XOR,  rd_s);
          FN_NOR:  op = mk_rtype(CTRL_NOR,  rd_s);
          FN_SLT:  op = mk_rtype(CTRL_SLT,  rd_s);
          FN_SLTU: op = mk_rtype(CTRL_SLTU, rd_s);
          default: op = mk_invalid();
        endcase
      end
      OP_ADDI:  op = mk_itype(CTRL_ADD,  sext16(imm16_s), rt_s);
      OP_ADDIU: op = mk_itype(CTRL_ADDU, sext16(imm16_s), rt_s);
      OP_SLTI:  op = mk_itype(CTRL_SLT,  sext16(imm16_s), rt_s);
      OP_SLTIU: op = mk_itype(CTRL_SLTU, sext16(imm16_s), rt_s);
      OP_ANDI:  op = mk_itype(CTRL_AND,  zext16(imm16_s), rt_s);
      OP_ORI:   op = mk_itype(CTRL_OR,   zext16(imm16_s), rt_s);
      OP_XORI:  op = mk_itype(CTRL_XOR,  zext16(imm16_s), rt_s);
      OP_LUI:   op = mk_itype(CTRL_LUI,  zext16(imm16_s), rt_s);
      OP_BEQ:   op = mk_branch(CTRL_SUBU, BR_EQ);
      OP_BNE:   op = mk_branch(CTRL_SUBU, BR_NE);
      OP_BLEZ:  op = mk_branch(CTRL_BLEZ, BR_CMP);
      OP_BGTZ:  op = mk_branch(CTRL_BGTZ, BR_CMP);
      OP_REGIMM: begin
        if (rt_s == RT_BLTZ) begin
          op = mk_branch(CTRL_BLTZ, BR_CMP);
        end else if (rt_s == RT_BGEZ) begin
          op = mk_branch(CTRL_BGEZ, BR_CMP);
        end else begin
          op = mk_invalid();
        end
      end
      default: op = mk_invalid();
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: decodes an instruction into a registered EX stage
// that drives the ALU, then captures the ALU flags into a result stage that
// resolves branch, overflow/reserved exceptions and writeback enable.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_CTRL = 4'b0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [3:0]  alu_ctrl,
  output logic        alu_b_sel,
  output logic [31:0] alu_imm,
  output logic        ex_valid,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_compare,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_branch_taken,
  output logic        res_exc_ovf,
  output logic        res_exc_ri,
  output logic        res_wb_en,
  output logic [4:0]  res_wb_reg
);

  dec_op_t  dec_s;
  logic     adv_s;
  logic     accept_s;

  // EX-stage side information not presented to the ALU
  logic     ex_wb_r;
  logic [4:0] ex_wb_reg_r;
  logic     ex_is_branch_r;
  br_kind_e ex_br_kind_r;
  logic     ex_ri_r;

  // Result-stage next values computed from the live ALU flags
  logic     taken_s;
  logic     exc_ovf_s;
  logic     wb_en_s;

  alu_op_decode u_decode (
    .instr (in_instr),
    .op    (dec_s)
  );

  // EX can hand its op forward whenever the result slot is free or draining;
  // a flush blocks new instructions in the same cycle.
  assign adv_s    = ex_valid && (!res_valid || res_ready);
  assign in_ready = !flush && (!ex_valid || adv_s);
  assign accept_s = in_valid && in_ready;

  // Resolve branch, overflow and writeback from the flags of the op in EX
  always_comb begin
    taken_s   = 1'b0;
    exc_ovf_s = alu_overflow && is_trap_arith(alu_ctrl);
    if (ex_is_branch_r) begin
      case (ex_br_kind_r)
        BR_EQ:   taken_s = alu_zero;
        BR_NE:   taken_s = !alu_zero;
        BR_CMP:  taken_s = alu_compare;
        default: taken_s = 1'b0;
      endcase
    end else begin
      taken_s = 1'b0;
    end
    wb_en_s = ex_wb_r && !exc_ovf_s && !ex_ri_r && (ex_wb_reg_r != 5'd0);
  end

  // EX stage register: load on accept, idle the ALU inputs once emptied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid       <= 1'b0;
      alu_ctrl       <= RESET_CTRL;
      alu_b_sel      <= 1'b0;
      alu_imm        <= 32'h0000_0000;
      ex_wb_r        <= 1'b0;
      ex_wb_reg_r    <= 5'd0;
      ex_is_branch_r <= 1'b0;
      ex_br_kind_r   <= BR_NONE;
      ex_ri_r        <= 1'b0;
    end else if (flush) begin
      ex_valid       <= 1'b0;
      alu_ctrl       <= RESET_CTRL;
      alu_b_sel      <= 1'b0;
      alu_imm        <= 32'h0000_0000;
      ex_wb_r        <= 1'b0;
      ex_wb_reg_r    <= 5'd0;
      ex_is_branch_r <= 1'b0;
      ex_br_kind_r   <= BR_NONE;
      ex_ri_r        <= 1'b0;
    end else if (accept_s) begin
      ex_valid       <= 1'b1;
      alu_ctrl       <= dec_s.ctrl;
      alu_b_sel      <= dec_s.b_sel;
      alu_imm        <= dec_s.imm;
      ex_wb_r        <= dec_s.wb;
      ex_wb_reg_r    <= dec_s.wb_reg;
      ex_is_branch_r <= dec_s.is_branch;
      ex_br_kind_r   <= dec_s.br_kind;
      ex_ri_r        <= dec_s.ri;
    end else if (adv_s) begin
      ex_valid       <= 1'b0;
      alu_ctrl       <= RESET_CTRL;
      alu_b_sel      <= 1'b0;
      alu_imm        <= 32'h0000_0000;
    end else begin
      ex_valid       <= ex_valid;
    end
  end

  // Result stage register: capture flags on advance, drop when consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid        <= 1'b0;
      res_branch_taken <= 1'b0;
      res_exc_ovf      <= 1'b0;
      res_exc_ri       <= 1'b0;
      res_wb_en        <= 1'b0;
      res_wb_reg       <= 5'd0;
    end else if (flush) begin
      res_valid        <= 1'b0;
      res_branch_taken <= 1'b0;
      res_exc_ovf      <= 1'b0;
      res_exc_ri       <= 1'b0;
      res_wb_en        <= 1'b0;
      res_wb_reg       <= 5'd0;
    end else if (adv_s) begin
      res_valid        <= 1'b1;
      res_branch_taken <= taken_s;
      res_exc_ovf      <= exc_ovf_s;
      res_exc_ri       <= ex_ri_r;
      res_wb_en        <= wb_en_s;
      res_wb_reg       <= ex_wb_reg_r;
    end else if (res_valid && res_ready) begin
      res_valid        <= 1'b0;
    end else begin
      res_valid        <= res_valid;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: table of single-instruction
// vectors plus directed backpressure, flush and reset-in-stall sequences.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [3:0]  alu_ctrl;
  logic        alu_b_sel;
  logic [31:0] alu_imm;
  logic        ex_valid;
  logic        alu_zero;
  logic        alu_overflow;
  logic        alu_compare;
  logic        res_valid;
  logic        res_ready;
  logic        res_branch_taken;
  logic        res_exc_ovf;
  logic        res_exc_ri;
  logic        res_wb_en;
  logic [4:0]  res_wb_reg;

  int checks;
  int errors;

  alu_issue_ctrl #(.RESET_CTRL(4'b0000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_instr         (in_instr),
    .alu_ctrl         (alu_ctrl),
    .alu_b_sel        (alu_b_sel),
    .alu_imm          (alu_imm),
    .ex_valid         (ex_valid),
    .alu_zero         (alu_zero),
    .alu_overflow     (alu_overflow),
    .alu_compare      (alu_compare),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_branch_taken (res_branch_taken),
    .res_exc_ovf      (res_exc_ovf),
    .res_exc_ri       (res_exc_ri),
    .res_wb_en        (res_wb_en),
    .res_wb_reg       (res_wb_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        z;
    logic        o;
    logic        c;
    logic [3:0]  ctrl;
    logic        bsel;
    logic [31:0] imm;
    logic        taken;
    logic        ovf;
    logic        ri;
    logic        wben;
    logic [4:0]  wbreg;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //           name     instr         z     o     c     ctrl     bsel  imm            tk    ovf   ri    wben  wbreg
    vecs[0]  = '{"add",   32'h00221820, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3};
    vecs[1]  = '{"addov", 32'h00221820, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3};
    vecs[2]  = '{"adduo", 32'h00221821, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3};
    vecs[3]  = '{"addi",  32'h2022FFFF, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2};
    vecs[4]  = '{"ori",   32'h3422FFFF, 1'b0, 1'b0, 1'b0, 4'b0101, 1'b1, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2};
    vecs[5]  = '{"lui",   32'h3C051234, 1'b0, 1'b0, 1'b0, 4'b1110, 1'b1, 32'h00001234, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5};
    vecs[6]  = '{"beq",   32'h10220004, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[7]  = '{"bgtz",  32'h1C200004, 1'b0, 1'b0, 1'b0, 4'b1100, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[8]  = '{"op3f",  32'hFC000000, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0};
    vecs[9]  = '{"bne",   32'h14220004, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[10] = '{"bltz",  32'h04200004, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[11] = '{"bgez",  32'h04210004, 1'b1, 1'b0, 1'b1, 4'b1101, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[12] = '{"rimm2", 32'h04220004, 1'b0, 1'b0, 1'b1, 4'b1111, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0};
    vecs[13] = '{"subov", 32'h00221822, 1'b0, 1'b1, 1'b0, 4'b0011, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3};
    vecs[14] = '{"addr0", 32'h00220020, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0};
    vecs[15] = '{"sll",   32'h00221800, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0};
    vecs[16] = '{"slt",   32'h0022182A, 1'b0, 1'b0, 1'b1, 4'b1001, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3};
    vecs[17] = '{"slti",  32'h2822FFFF, 1'b0, 1'b1, 1'b0, 4'b1001, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2};

    rst_n        = 1'b0;
    flush        = 1'b0;
    in_valid     = 1'b0;
    in_instr     = 32'h0000_0000;
    alu_zero     = 1'b0;
    alu_overflow = 1'b0;
    alu_compare  = 1'b0;
    res_ready    = 1'b1;

    // Reset state
    #3;
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_alu_ctrl", alu_ctrl, 4'b0000);
    chk("rst_b_sel", alu_b_sel, 1'b0);
    chk("rst_imm", alu_imm, 32'h0);
    chk("rst_res_out", {res_branch_taken, res_exc_ovf, res_exc_ri, res_wb_en, res_wb_reg}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven single instructions, no backpressure
    for (int i = 0; i < NV; i++) begin
      in_valid     = 1'b1;
      in_instr     = vecs[i].instr;
      alu_zero     = vecs[i].z;
      alu_overflow = vecs[i].o;
      alu_compare  = vecs[i].c;
      @(negedge clk);
      chk({vecs[i].name, "_in_ready"}, in_ready, 1'b1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk({vecs[i].name, "_ex_valid"}, ex_valid, 1'b1);
      chk({vecs[i].name, "_ctrl"}, alu_ctrl, vecs[i].ctrl);
      chk({vecs[i].name, "_b_sel"}, alu_b_sel, vecs[i].bsel);
      if (vecs[i].bsel) begin
        chk({vecs[i].name, "_imm"}, alu_imm, vecs[i].imm);
      end else begin
        chk({vecs[i].name, "_res_idle"}, res_valid, 1'b0);
      end
      @(posedge clk);
      @(negedge clk);
      chk({vecs[i].name, "_res_valid"}, res_valid, 1'b1);
      chk({vecs[i].name, "_taken"}, res_branch_taken, vecs[i].taken);
      chk({vecs[i].name, "_ovf"}, res_exc_ovf, vecs[i].ovf);
      chk({vecs[i].name, "_ri"}, res_exc_ri, vecs[i].ri);
      chk({vecs[i].name, "_wb_en"}, res_wb_en, vecs[i].wben);
      chk({vecs[i].name, "_wb_reg"}, res_wb_reg, vecs[i].wbreg);
      @(posedge clk);
      #1;
    end

    alu_zero     = 1'b0;
    alu_overflow = 1'b0;
    alu_compare  = 1'b0;

    // Backpressure: add(rd3), ori(rt2), lui(rt5) with res_ready low
    res_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00221820;
    @(posedge clk);
    #1;
    in_instr = 32'h3422FFFF;
    @(posedge clk);
    #1;
    in_instr = 32'h3C051234;
    @(negedge clk);
    chk("bp_in_ready_lo", in_ready, 1'b0);
    chk("bp_ctrl", alu_ctrl, 4'b0101);
    chk("bp_res_valid", res_valid, 1'b1);
    chk("bp_res_reg_a", res_wb_reg, 5'd3);
    @(posedge clk);
    @(negedge clk);
    chk("bp_hold_ctrl", alu_ctrl, 4'b0101);
    chk("bp_hold_imm", alu_imm, 32'h0000FFFF);
    chk("bp_hold_in_ready", in_ready, 1'b0);
    chk("bp_hold_res_reg", res_wb_reg, 5'd3);
    chk("bp_hold_res_valid", res_valid, 1'b1);
    res_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_res_b_valid", res_valid, 1'b1);
    chk("bp_res_b_reg", res_wb_reg, 5'd2);
    chk("bp_ctrl_c", alu_ctrl, 4'b1110);
    @(posedge clk);
    @(negedge clk);
    chk("bp_res_c_valid", res_valid, 1'b1);
    chk("bp_res_c_reg", res_wb_reg, 5'd5);
    chk("bp_ex_empty", ex_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_drained", res_valid, 1'b0);
    @(posedge clk);
    #1;

    // Flush in the middle of a stall
    res_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00221820;
    @(posedge clk);
    #1;
    in_instr = 32'h3422FFFF;
    @(posedge clk);
    #1;
    in_instr = 32'h3C051234;
    flush    = 1'b1;
    @(negedge clk);
    chk("fl_in_ready", in_ready, 1'b0);
    chk("fl_pre_ex", ex_valid, 1'b1);
    chk("fl_pre_res", res_valid, 1'b1);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl_ex_valid", ex_valid, 1'b0);
    chk("fl_res_valid", res_valid, 1'b0);
    chk("fl_ctrl", alu_ctrl, 4'b0000);
    chk("fl_imm", alu_imm, 32'h0);
    @(posedge clk);
    #1;

    // Flush with an empty pipeline blocks the offered instruction
    res_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h3C051234;
    flush     = 1'b1;
    @(negedge clk);
    chk("fl_empty_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("fl_empty_no_accept", ex_valid, 1'b0);
    @(posedge clk);
    #1;

    // Asynchronous reset during a stall
    res_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00221820;
    @(posedge clk);
    #1;
    in_instr = 32'h3422FFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_ex_valid", ex_valid, 1'b0);
    chk("rs_res_valid", res_valid, 1'b0);
    chk("rs_ctrl", alu_ctrl, 4'b0000);
    chk("rs_wb_reg", res_wb_reg, 5'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    res_ready = 1'b1;
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Initiator side of the combinational ALU interface. Decodes a MIPS instruction word into the 4-bit ALU control code and B-operand select/immediate, then presents them to the ALU from a registered EX stage. One cycle later it captures the ALU's Zero/Overflow/Compare flags into a result stage and resolves branch-taken, overflow and reserved-instruction exceptions, and the writeback enable. Two-stage valid/ready pipeline, throughput of 1 instruction per cycle, sitting between the fetch/register-read logic and writeback/PC-select.

Parameters:
RESET_CTRL, 4'b0000, ALU control value driven while the EX stage is idle or in reset.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of both pipeline stages
in_valid  input  1  instruction word valid
in_ready  output  1  instruction accepted when in_valid && in_ready
in_instr  input  32  MIPS instruction word
alu_ctrl  output  4  ALU control code (registered)
alu_b_sel  output  1  0 = register rt, 1 = alu_imm
alu_imm  output  32  extended immediate (registered)
ex_valid  output  1  EX stage holds a live operation
alu_zero  input  1  ALU Zero flag (combinational from alu_ctrl)
alu_overflow  input  1  ALU Overflow flag
alu_compare  input  1  ALU Compare flag
res_valid  output  1  result stage valid
res_ready  input  1  consumer accepts the result
res_branch_taken  output  1  branch condition true
res_exc_ovf  output  1  signed add/sub overflow
res_exc_ri  output  1  reserved/undecoded instruction
res_wb_en  output  1  register write required
res_wb_reg  output  5  destination register

Behaviour:
- Reset (rst_n=0, async): ex_valid=0, res_valid=0, alu_ctrl=RESET_CTRL, alu_b_sel=0, alu_imm=0, all res_* outputs 0.
- Control codes: addu 0000, add 0001, subu 0010, sub 0011, and 0100, or 0101, nor 0110, xor 0111, sltu 1000, slt 1001, bltz 1010, blez 1011, bgtz 1100, bgez 1101, lui 1110, invalid 1111.
- R-type (opcode 000000) funct: 100000 add, 100001 addu, 100010 sub, 100011 subu, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt, 101011 sltu. b_sel=0, wb_reg=rd.
- I-type: 001000 addi and 001001 addiu use sign-extended immediates; 001010 slti and 001011 sltiu use sign-extended immediates; 001100 andi, 001101 ori and 001110 xori use zero-extended immediates; 001111 lui uses a zero-extended immediate (the ALU shifts it). b_sel=1, wb_reg=rt.
- Branches (no writeback): 000100 beq uses 0010 and is taken when Zero=1. 000101 bne uses 0010 and is taken when Zero=0. 000001 with rt=00000 is bltz; 000001 with rt=00001 is bgez. 000110 is blez and 000111 is bgtz. For bltz, bgez, blez and bgtz the branch is taken when Compare=1.
- Any other encoding: alu_ctrl=1111, exc_ri=1, wb_en=0, branch_taken=0.
- Pipeline: adv = ex_valid && (!res_valid || res_ready). in_ready = !ex_valid || adv.
  - On acceptance, the EX registers load the decoded instruction.
  - On adv, the result registers capture the flags sampled in that cycle and res_valid=1.
  - If res_valid && res_ready && !adv, res_valid goes to 0.
- Latency: accept in cycle N, then alu_ctrl is valid in cycle N+1 and res_valid is 1 in cycle N+2 when there is no backpressure.
- Stall: while res_valid && !res_ready, the EX stage holds alu_ctrl and alu_imm unchanged, so the ALU outputs stay stable.
- exc_ovf = alu_overflow, only for codes 0001 and 0011; 0 otherwise.
- res_wb_en = writes-register && !exc_ovf && !exc_ri && (wb_reg != 0).
- Flush: next cycle ex_valid=0 and res_valid=0. The in_instr presented in the same cycle is not accepted (in_ready=0 while flush=1). alu_ctrl returns to RESET_CTRL.
- Flush takes priority over accept, advance and hold.
- Reset asserted mid-stall discards all state immediately.

Decomposition:
- Package alu_ctrl_pkg: ALU control code constants, opcode/funct/REGIMM-rt constants, and a decoded-op struct (ctrl, b_sel, imm, wb, wb_reg, is_branch, br_kind, ri).
- Sub-module alu_op_decode: purely combinational instruction-to-struct decode, instantiated ahead of the EX register.

Test Plan:
- add $3,$1,$2 (0x00221820), flags 0/0/0, res_ready=1 -> alu_ctrl=0001 and b_sel=0 at N+1; at N+2 res_valid=1, wb_en=1, wb_reg=3, exc_ovf=0.
- Same instruction with alu_overflow=1 -> exc_ovf=1, wb_en=0. addu (0x00221821) with alu_overflow=1 -> exc_ovf=0, wb_en=1.
- addi $2,$1,-1 (0x2022FFFF) -> alu_imm=0xFFFFFFFF, b_sel=1, wb_reg=2. ori (0x3422FFFF) -> alu_imm=0x0000FFFF. lui $5,0x1234 (0x3C051234) -> ctrl=1110, imm=0x00001234.
- beq (0x10220004) with Zero=1 -> branch_taken=1, wb_en=0. bgtz (0x1C200004) with Compare=0 -> branch_taken=0.
- Opcode 0x3F (0xFC000000) -> alu_ctrl=1111, exc_ri=1, wb_en=0.
- Backpressure and flush: three back-to-back instructions with res_ready=0 -> in_ready=0 after 2 accepts and alu_ctrl held. Release -> one result per cycle, in order. Flush mid-stall -> res_valid=0 and ex_valid=0 next cycle.
